// File: rtl/dct_pkg.sv
// Shared constants and bus-slicing helpers for the 8-point 1-D DCT.
// Holds fixed-point format, vector length and accumulator sizing.
package dct_pkg;

    localparam int FRAC_BITS      = 16;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int N              = 8;
    localparam int ACC_WIDTH      = 2 * DEF_DATA_WIDTH + 3;

    // Eight full-width products need three extra bits of headroom.
    function automatic int acc_width(input int dw);
        return 2 * dw + 3;
    endfunction

    // Low bit of lane idx on a packed bus of dw-bit lanes.
    function automatic int lane_lo(input int idx, input int dw);
        return idx * dw;
    endfunction

    // Low bit of coeff[k][n] on the row-major packed coefficient bus.
    function automatic int coeff_lo(input int k, input int n, input int dw);
        return (k * N + n) * dw;
    endfunction

endpackage

// File: rtl/dct_mac8.sv
// One DCT output row: 8 registered products, adder tree, shift, output reg.
// Ports: clk, reset_n (async low), data/coeff (8 lanes), result (1 lane).
// Build option: DCT_1D_ROUND_EN selects round-half-up instead of floor.
module dct_mac8
    import dct_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [N*DATA_WIDTH-1:0] data,
    input  logic [N*DATA_WIDTH-1:0] coeff,
    output logic [DATA_WIDTH-1:0]   result
);

    localparam int PW = 2 * DATA_WIDTH;
    localparam int AW = acc_width(DATA_WIDTH);

    logic signed [PW-1:0] prod_d [N];
    logic signed [PW-1:0] prod_q [N];
    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] rnd;
    logic                 unused_bits;

    for (genvar n = 0; n < N; n++) begin : g_prod
        logic [DATA_WIDTH-1:0] s;
        logic [DATA_WIDTH-1:0] c;
        assign s = data[lane_lo(n, DATA_WIDTH) +: DATA_WIDTH];
        assign c = coeff[lane_lo(n, DATA_WIDTH) +: DATA_WIDTH];
        // Operands widened first so the product keeps every bit.
        assign prod_d[n] = $signed({{DATA_WIDTH{s[DATA_WIDTH-1]}}, s})
                         * $signed({{DATA_WIDTH{c[DATA_WIDTH-1]}}, c});
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int n = 0; n < N; n++) begin
                prod_q[n] <= '0;
            end
        end else begin
            for (int n = 0; n < N; n++) begin
                prod_q[n] <= prod_d[n];
            end
        end
    end

    always_comb begin
        acc = '0;
        for (int n = 0; n < N; n++) begin
            acc = acc + AW'(prod_q[n]);
        end
    end

`ifdef DCT_1D_ROUND_EN
    localparam logic signed [AW-1:0] HALF = AW'(1) << (FRAC_BITS - 1);
    assign rnd = acc + HALF;
`else
    assign rnd = acc;
`endif

    // Taking bits above FRAC_BITS is an arithmetic shift (floor); the
    // top bits are dropped so out-of-range results wrap.
    assign unused_bits = ^{rnd[AW-1:FRAC_BITS+DATA_WIDTH],
                           rnd[FRAC_BITS-1:0]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            result <= '0;
        end else begin
            result <= rnd[FRAC_BITS +: DATA_WIDTH];
        end
    end

endmodule

// File: rtl/dct_1d_8x1.sv
// 8-point 1-D DCT: dct_out[k] = sum_n coeff[k][n]*data_in[n], Q16.16, 2-cycle latency.
// Ports: clk, reset_n (async low), data_in, coeff_vector (row-major), dct_out.
// Build option: DCT_1D_ROUND_EN selects round-half-up instead of floor.
module dct_1d_8x1
    import dct_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [N*DATA_WIDTH-1:0]   data_in,
    input  logic [N*N*DATA_WIDTH-1:0] coeff_vector,
    output logic [N*DATA_WIDTH-1:0]   dct_out
);

    for (genvar k = 0; k < N; k++) begin : g_row
        // Row k of the matrix is contiguous on the row-major bus.
        dct_mac8 #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_mac (
            .clk     (clk),
            .reset_n (reset_n),
            .data    (data_in),
            .coeff   (coeff_vector[coeff_lo(k, 0, DATA_WIDTH) +: N*DATA_WIDTH]),
            .result  (dct_out[lane_lo(k, DATA_WIDTH) +: DATA_WIDTH])
        );
    end

endmodule

// File: tb/tb_dct_1d_8x1.sv
// Directed self-checking bench for dct_1d_8x1 (DATA_WIDTH = 32).
// Expected values are hand-computed Q16.16 constants.
module tb_dct_1d_8x1;

    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [8*DW-1:0] data_in;
    logic [64*DW-1:0] coeff_vector;
    logic [8*DW-1:0] dct_out;

    int checks = 0;
    int errors = 0;

    dct_1d_8x1 #(.DATA_WIDTH(DW)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .data_in      (data_in),
        .coeff_vector (coeff_vector),
        .dct_out      (dct_out)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    function automatic logic [DW-1:0] lane(input int k);
        return dct_out[k*DW +: DW];
    endfunction

    task automatic check(input string tag, input logic [DW-1:0] obs,
                         input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic set_identity();
        coeff_vector = '0;
        for (int k = 0; k < 8; k++)
            coeff_vector[(k*8+k)*DW +: DW] = 32'h0001_0000;
    endtask

    task automatic set_ramp(input logic [DW-1:0] step);
        for (int n = 0; n < 8; n++)
            data_in[n*DW +: DW] = DW'(n) * step;
    endtask

    task automatic edges(input int cnt);
        repeat (cnt) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset_n      = 1'b0;
        data_in      = '0;
        coeff_vector = '0;
        #12;
        check("reset_lane0", lane(0), 32'h0);
        check("reset_lane7", lane(7), 32'h0);

        // Zero data, arbitrary coefficients
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 64; i++)
            coeff_vector[i*DW +: DW] = $urandom;
        edges(2);
        for (int k = 0; k < 8; k++)
            check($sformatf("zero_k%0d", k), lane(k), 32'h0);

        // Identity, ramp data
        set_identity();
        set_ramp(32'h0001_0000);
        edges(2);
        for (int k = 0; k < 8; k++)
            check($sformatf("ident_k%0d", k), lane(k), DW'(k) << 16);

        // Identity, all -1.0
        for (int n = 0; n < 8; n++)
            data_in[n*DW +: DW] = 32'hFFFF_0000;
        edges(2);
        for (int k = 0; k < 8; k++)
            check($sformatf("neg_k%0d", k), lane(k), 32'hFFFF_0000);

        // Row 3 all 1.0, others identity: lane3 = 0+..+7 = 28.0
        set_ramp(32'h0001_0000);
        for (int n = 0; n < 8; n++)
            coeff_vector[(3*8+n)*DW +: DW] = 32'h0001_0000;
        edges(2);
        check("sum_k3", lane(3), 32'h001C_0000);
        check("sum_k5", lane(5), 32'h0005_0000);

        // 2.5 * 3.0 = 7.5 on lane 1
        set_identity();
        data_in = '0;
        coeff_vector[(1*8+1)*DW +: DW] = 32'h0002_8000;
        data_in[1*DW +: DW] = 32'h0003_0000;
        edges(2);
        check("frac_k1", lane(1), 32'h0007_8000);

        // Rounding: 0.5 * 2^-16
        coeff_vector = '0;
        data_in      = '0;
        coeff_vector[0 +: DW] = 32'h0000_8000;
        data_in[0 +: DW]      = 32'h0000_0001;
        edges(2);
`ifdef DCT_1D_ROUND_EN
        check("round_pos", lane(0), 32'h0000_0001);
`else
        check("round_pos", lane(0), 32'h0000_0000);
`endif
        check("round_k1", lane(1), 32'h0);

        // Negative half LSB
        data_in[0 +: DW] = 32'hFFFF_FFFF;
        edges(2);
`ifdef DCT_1D_ROUND_EN
        check("round_neg", lane(0), 32'h0000_0000);
`else
        check("round_neg", lane(0), 32'hFFFF_FFFF);
`endif

        // Latency: zeros, then A, then B on consecutive cycles
        set_identity();
        data_in = '0;
        edges(2);
        set_ramp(32'h0001_0000);
        edges(1);
        check("lat_e1", lane(2), 32'h0);
        set_ramp(32'h0002_0000);
        edges(1);
        check("lat_e2_A", lane(2), 32'h0002_0000);
        edges(1);
        check("lat_e3_B", lane(2), 32'h0004_0000);

        // Asynchronous reset between edges
        #1;
        reset_n = 1'b0;
        #1;
        check("async_rst_k2", lane(2), 32'h0);
        check("async_rst_k7", lane(7), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        edges(1);
        check("post_rst_e1", lane(2), 32'h0);
        edges(1);
        check("post_rst_e2", lane(2), 32'h0004_0000);
        check("post_rst_k7", lane(7), 32'h000E_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
